pipeline_stall_ctrl: RTL and testbench

Central stall and flush controller for the five-stage core pipeline (IF, ID, EX, MEM, WB). It merges per-stage stall requests into one monotonic stall vector, which drives the `stall_current_stage`/`stall_next_stage` pairs of every inter-stage pipeline register. It also sequences multi-cycle MUL/DIV operations in EX with an internal FSM and counter. On an exception or ERET it applies a one-cycle pipeline flush that overrides all stalls.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/mdu_sequencer.sv | 79 +++++++
 rtl/pipeline_stall_ctrl.sv | 79 +++++++
 tb/tb_pipeline_stall_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage core pipeline: stage indices, MDU sequencer
// state encoding and the stall-vector helper.
package pipeline_pkg;

  localparam int unsigned NUM_STAGES = 5;

  localparam int unsigned STAGE_IF  = 0;
  localparam int unsigned STAGE_ID  = 1;
  localparam int unsigned STAGE_EX  = 2;
  localparam int unsigned STAGE_MEM = 3;
  localparam int unsigned STAGE_WB  = 4;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // A stalled stage also stalls every earlier stage: stall[k] = |req[NUM_STAGES-1:k].
  function automatic logic [NUM_STAGES-1:0] stall_from_req(input logic [NUM_STAGES-1:0] req);
    logic [NUM_STAGES-1:0] s;
    s[NUM_STAGES-1] = req[NUM_STAGES-1];
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      s[k] = s[k+1] | req[k];
    end
    return s;
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV sequencer: holds EX for MDU_LATENCY cycles, then presents a
// one-or-more-cycle DONE window that persists while MEM keeps EX stalled.
module mdu_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = $clog2(MDU_LATENCY)
) (
  input  logic clk,
  input  logic rst,
  input  logic mdu_start,
  input  logic hold,
  input  logic flush,
  output logic req_ex,
  output logic mdu_busy,
  output logic mdu_done
);

  // The IDLE request cycle counts as the first of MDU_LATENCY, so BUSY runs
  // MDU_LATENCY-1 cycles: count values MDU_LATENCY-2 down to 0.
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MDU_LATENCY - 2);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (mdu_start && !hold) begin
            state_q <= MDU_BUSY;
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
          end
        end
        MDU_BUSY: begin
          // MEM stalls do not pause the arithmetic; only the retire waits.
          if (cnt_q == '0) begin
            state_q <= MDU_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MDU_DONE: begin
          if (!hold) begin
            state_q <= MDU_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ex   = ((state_q == MDU_IDLE) && mdu_start) || (state_q == MDU_BUSY);
  assign mdu_busy = busy_q;
  assign mdu_done = done_q;

  a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst)
    busy_q == (state_q == MDU_BUSY));

  a_done_matches_state: assert property (@(posedge clk) disable iff (!rst)
    done_q == (state_q == MDU_DONE));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: merges per-stage stall requests into a monotonic
// stall vector, sequences MUL/DIV in EX and applies the exception flush.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = $clog2(MDU_LATENCY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ready,
  input  logic                  load_related,
  input  logic                  mdu_start,
  input  logic                  mem_access,
  input  logic                  ram_ready,
  input  logic                  exc_flush,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic                  mdu_busy,
  output logic                  mdu_done
);

  logic [NUM_STAGES-1:0] req;
  logic [NUM_STAGES-1:0] stall_raw;
  logic                  req_mem;
  logic                  req_ex;
  logic                  seq_busy;
  logic                  seq_done;

  assign req_mem = mem_access && !ram_ready;

  always_comb begin
    req            = '0;
    req[STAGE_IF]  = !rom_ready;
    req[STAGE_ID]  = load_related;
    req[STAGE_EX]  = req_ex;
    req[STAGE_MEM] = req_mem;
    req[STAGE_WB]  = 1'b0;
  end

  assign stall_raw = stall_from_req(req);

  // stall[MEM] reduces to req_mem since WB never stalls; in DONE req_ex is 0, so
  // stall[EX] reduces to the same term and one hold signal serves both uses.
  mdu_sequencer #(
    .MDU_LATENCY(MDU_LATENCY),
    .CNT_W      (CNT_W)
  ) u_mdu_seq (
    .clk      (clk),
    .rst      (rst),
    .mdu_start(mdu_start),
    .hold     (req_mem),
    .flush    (exc_flush),
    .req_ex   (req_ex),
    .mdu_busy (seq_busy),
    .mdu_done (seq_done)
  );

  always_comb begin
    stall    = '0;
    flush    = 1'b0;
    mdu_busy = 1'b0;
    mdu_done = 1'b0;
    if (rst) begin
      flush    = exc_flush;
      stall    = exc_flush ? '0 : stall_raw;
      mdu_busy = seq_busy;
      mdu_done = seq_done;
    end
  end

  // Stall vector is always a thermometer code 0...01...1.
  a_stall_thermo: assert property (@(posedge clk)
    ((stall + NUM_STAGES'(1)) & stall) == '0);

  a_flush_clears_stall: assert property (@(posedge clk)
    flush |-> (stall == '0));

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus randomized
// stimulus compared against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned L = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rom_ready;
  logic       load_related;
  logic       mdu_start;
  logic       mem_access;
  logic       ram_ready;
  logic       exc_flush;
  logic [4:0] stall;
  logic       flush;
  logic       mdu_busy;
  logic       mdu_done;

  int checks = 0;
  int errors = 0;

  // Reference model: busy cycles still to run and whether a result is waiting to retire.
  int busy_left = 0;
  bit in_done   = 1'b0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .MDU_LATENCY(L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ready   (rom_ready),
    .load_related(load_related),
    .mdu_start   (mdu_start),
    .mem_access  (mem_access),
    .ram_ready   (ram_ready),
    .exc_flush   (exc_flush),
    .stall       (stall),
    .flush       (flush),
    .mdu_busy    (mdu_busy),
    .mdu_done    (mdu_done)
  );

  function automatic logic [7:0] obs();
    return {stall, flush, mdu_busy, mdu_done};
  endfunction

  // Expected {stall, flush, busy, done} from the current inputs and model state.
  function automatic logic [7:0] model_expect();
    bit         idle;
    bit   [4:0] rq;
    int         h;
    logic [4:0] s;
    idle  = (busy_left == 0) && !in_done;
    rq[0] = !rom_ready;
    rq[1] = load_related;
    rq[2] = (idle && mdu_start) || (busy_left > 0);
    rq[3] = mem_access && !ram_ready;
    rq[4] = 1'b0;
    h = -1;
    for (int i = 0; i < 5; i++) if (rq[i]) h = i;
    s = (h < 0) ? 5'd0 : 5'((1 << (h + 1)) - 1);
    if (!rst) return 8'd0;
    if (exc_flush) return {5'd0, 1'b1, busy_left > 0, in_done};
    return {s, 1'b0, busy_left > 0, in_done};
  endfunction

  task automatic model_tick();
    bit mem_stall;
    mem_stall = mem_access && !ram_ready;
    if (!rst || exc_flush) begin
      busy_left = 0;
      in_done   = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) in_done = 1'b1;
    end else if (in_done) begin
      if (!mem_stall) in_done = 1'b0;
    end else if (mdu_start && !mem_stall) begin
      busy_left = L - 1;
    end
  endtask

  task automatic drive_idle();
    rst          = 1'b1;
    rom_ready    = 1'b1;
    load_related = 1'b0;
    mdu_start    = 1'b0;
    mem_access   = 1'b0;
    ram_ready    = 1'b1;
    exc_flush    = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      rst          = 1'b0;
      rom_ready    = 1'($urandom_range(0, 1));
      load_related = 1'($urandom_range(0, 1));
      mdu_start    = 1'($urandom_range(0, 1));
      mem_access   = 1'($urandom_range(0, 1));
      ram_ready    = 1'($urandom_range(0, 1));
      exc_flush    = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs() !== 8'd0) begin
        errors++;
        $display("FAIL test_reset cyc %0d: got %b want %b", c, obs(), 8'd0);
      end
      advance();
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (obs() !== 8'd0) begin
      errors++;
      $display("FAIL test_reset idle_after: got %b want %b", obs(), 8'd0);
    end
    advance();
  endtask

  task automatic test_single_requests();
    logic [7:0] exp_t [3];
    exp_t[0] = 8'b00001_0_0_0;
    exp_t[1] = 8'b00011_0_0_0;
    exp_t[2] = 8'b01111_0_0_0;
    for (int c = 0; c < 3; c++) begin
      drive_idle();
      rom_ready    = (c != 0);
      load_related = (c == 1);
      mem_access   = (c == 2);
      ram_ready    = (c != 2);
      @(negedge clk);
      checks++;
      if (obs() !== exp_t[c]) begin
        errors++;
        $display("FAIL test_single_requests case %0d: got %b want %b", c, obs(), exp_t[c]);
      end
      advance();
    end
  endtask

  task automatic test_simultaneous();
    drive_idle();
    rom_ready  = 1'b0;
    mem_access = 1'b1;
    ram_ready  = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== 8'b01111_0_0_0) begin
      errors++;
      $display("FAIL test_simultaneous if_mem: got %b want %b", obs(), 8'b01111_0_0_0);
    end
    advance();
    exc_flush    = 1'b1;
    load_related = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 8'b00000_1_0_0) begin
      errors++;
      $display("FAIL test_simultaneous flush: got %b want %b", obs(), 8'b00000_1_0_0);
    end
    advance();
    drive_idle();
  endtask

  task automatic test_mdu_run();
    logic [7:0] exp_t [6];
    exp_t[0] = 8'b00111_0_0_0;
    exp_t[1] = 8'b00111_0_1_0;
    exp_t[2] = 8'b00111_0_1_0;
    exp_t[3] = 8'b00111_0_1_0;
    exp_t[4] = 8'b00000_0_0_1;
    exp_t[5] = 8'b00000_0_0_0;
    for (int c = 0; c < 6; c++) begin
      drive_idle();
      mdu_start = (c < 5);
      @(negedge clk);
      checks++;
      if (obs() !== exp_t[c]) begin
        errors++;
        $display("FAIL test_mdu_run cyc %0d: got %b want %b", c, obs(), exp_t[c]);
      end
      advance();
    end
  endtask

  task automatic test_mem_stall_mdu();
    logic [7:0] exp_t [11];
    bit         mst_t [11];
    for (int c = 0; c < 11; c++) mst_t[c] = (c < 3) || (c == 7) || (c == 8);
    exp_t[0]  = 8'b01111_0_0_0;
    exp_t[1]  = 8'b01111_0_0_0;
    exp_t[2]  = 8'b01111_0_0_0;
    exp_t[3]  = 8'b00111_0_0_0;
    exp_t[4]  = 8'b00111_0_1_0;
    exp_t[5]  = 8'b00111_0_1_0;
    exp_t[6]  = 8'b00111_0_1_0;
    exp_t[7]  = 8'b01111_0_0_1;
    exp_t[8]  = 8'b01111_0_0_1;
    exp_t[9]  = 8'b00000_0_0_1;
    exp_t[10] = 8'b00000_0_0_0;
    for (int c = 0; c < 11; c++) begin
      drive_idle();
      mdu_start  = (c < 10);
      mem_access = mst_t[c];
      ram_ready  = !mst_t[c];
      @(negedge clk);
      checks++;
      if (obs() !== exp_t[c]) begin
        errors++;
        $display("FAIL test_mem_stall_mdu cyc %0d: got %b want %b", c, obs(), exp_t[c]);
      end
      advance();
    end
  endtask

  // Abort an MDU run in its second BUSY cycle by flush or by reset, then restart.
  task automatic test_abort(input bit use_rst, input string name);
    logic [7:0] exp_t [9];
    exp_t[0] = 8'b00111_0_0_0;
    exp_t[1] = 8'b00111_0_1_0;
    exp_t[2] = use_rst ? 8'b00000_0_0_0 : 8'b00000_1_1_0;
    exp_t[3] = 8'b00111_0_0_0;
    exp_t[4] = 8'b00111_0_1_0;
    exp_t[5] = 8'b00111_0_1_0;
    exp_t[6] = 8'b00111_0_1_0;
    exp_t[7] = 8'b00000_0_0_1;
    exp_t[8] = 8'b00000_0_0_0;
    for (int c = 0; c < 9; c++) begin
      drive_idle();
      mdu_start = (c < 8);
      if (c == 2) begin
        if (use_rst) rst = 1'b0;
        else exc_flush = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (obs() !== exp_t[c]) begin
        errors++;
        $display("FAIL %s cyc %0d: got %b want %b", name, c, obs(), exp_t[c]);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 49) != 0);
      exc_flush    = ($urandom_range(0, 29) == 0);
      rom_ready    = ($urandom_range(0, 4) != 0);
      load_related = ($urandom_range(0, 4) == 0);
      mem_access   = 1'($urandom_range(0, 1));
      ram_ready    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) mdu_start = !mdu_start;
      @(negedge clk);
      e = model_expect();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_random cyc %0d: got %b want %b", c, obs(), e);
      end
      advance();
    end
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    #1;
    test_reset();
    test_single_requests();
    test_simultaneous();
    test_mdu_run();
    test_mem_stall_mdu();
    test_abort(1'b0, "test_flush_mid_mdu");
    test_abort(1'b1, "test_reset_mid_mdu");
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
